// File: rtl/add_np_pkg.sv
// Shared constants and segment-geometry helpers for the add_np pipelined adder.
// Segment k starts at k*floor(WIDTH/SEGS); the top segment absorbs the remainder bits.
package add_np_pkg;

  localparam int unsigned DEF_WIDTH = 22;
  localparam int unsigned DEF_SEGS  = 3;

  // Enabled cycles from accepting valid_in to valid_out.
  function automatic int unsigned latency(input int unsigned segs);
    return segs + 1;
  endfunction

  localparam int unsigned DEF_LATENCY = latency(DEF_SEGS);

  function automatic int unsigned seg_lo(input int unsigned k, input int unsigned width,
                                         input int unsigned segs);
    return k * (width / segs);
  endfunction

  function automatic int unsigned seg_w(input int unsigned k, input int unsigned width,
                                        input int unsigned segs);
    if (k == segs - 1) return width - (segs - 1) * (width / segs);
    return width / segs;
  endfunction

endpackage

// File: rtl/add_np_if.sv
// Sample/result bus of add_np. The cout/ovf flag signals exist only when
// ADD_NP_OVF_EN is defined.
interface add_np_if #(
  parameter int unsigned WIDTH = 22
);

  logic             valid_in;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             valid_out;
  logic [WIDTH-1:0] sum;
`ifdef ADD_NP_OVF_EN
  logic             cout;
  logic             ovf;
`endif

  modport master (
    output valid_in, sub, x, y,
`ifdef ADD_NP_OVF_EN
    input  cout, ovf,
`endif
    input  valid_out, sum
  );

  modport slave (
    input  valid_in, sub, x, y,
`ifdef ADD_NP_OVF_EN
    output cout, ovf,
`endif
    output valid_out, sum
  );

endinterface

// File: rtl/add_seg.sv
// One carry segment: registered W-bit sum and carry out of a + b + cin.
module add_seg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ena,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= '0;
      cout <= 1'b0;
    end else if (ena) begin
      {cout, s} <= total;
    end
  end

endmodule

// File: rtl/add_np.sv
// add_np: SEGS-stage pipelined WIDTH-bit adder/subtractor, one sample per enabled cycle.
// Define ADD_NP_OVF_EN to add the cout/ovf flag outputs and their MSB pipeline.
module add_np
  import add_np_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEGS  = DEF_SEGS
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    ena,
  add_np_if.slave bus
);

  // xd/yd[k]: operands aligned with segment k's adder inputs.
  logic [WIDTH-1:0] xd     [SEGS];
  logic [WIDTH-1:0] yd     [SEGS];
  // low[k]: finished lower-segment results aligned with segment k's sum register.
  logic [WIDTH-1:0] low    [SEGS];
  logic [WIDTH-1:0] merged [SEGS];
  logic             seg_co [SEGS];
  logic [WIDTH-1:0] seg_s;
  logic [SEGS:0]    vd;
  logic             c0;

  function automatic logic [WIDTH-1:0] below_mask(input int unsigned k);
    return (WIDTH'(1) << seg_lo(k, WIDTH, SEGS)) - WIDTH'(1);
  endfunction

  // Shift by the full width wraps to zero, so a single full-width segment yields all ones.
  function automatic logic [WIDTH-1:0] slice_mask(input int unsigned k);
    return ((WIDTH'(1) << seg_w(k, WIDTH, SEGS)) - WIDTH'(1)) << seg_lo(k, WIDTH, SEGS);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      c0 <= 1'b0;
      vd <= '0;
      for (int unsigned k = 0; k < SEGS; k++) begin
        xd[k]  <= '0;
        yd[k]  <= '0;
        low[k] <= '0;
      end
    end else if (ena) begin
      xd[0]  <= bus.x;
      yd[0]  <= bus.sub ? ~bus.y : bus.y;
      c0     <= bus.sub;
      low[0] <= '0;
      vd     <= {vd[SEGS-1:0], bus.valid_in};
      for (int unsigned k = 1; k < SEGS; k++) begin
        xd[k]  <= xd[k-1];
        yd[k]  <= yd[k-1];
        low[k] <= merged[k-1];
      end
    end
  end

  // Splice each segment's registered sum above the results already delayed for it.
  always_comb begin
    for (int unsigned k = 0; k < SEGS; k++) begin
      merged[k] = (low[k] & below_mask(k)) | (seg_s & slice_mask(k));
    end
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    localparam int unsigned LO = seg_lo(k, WIDTH, SEGS);
    localparam int unsigned W  = seg_w(k, WIDTH, SEGS);
    logic cin;

    if (k == 0) begin : g_cin0
      assign cin = c0;
    end else begin : g_cinn
      assign cin = seg_co[k-1];
    end

    add_seg #(.W(W)) u_seg (
      .clk   (clk),
      .reset (reset),
      .ena   (ena),
      .a     (xd[k][LO +: W]),
      .b     (yd[k][LO +: W]),
      .cin   (cin),
      .s     (seg_s[LO +: W]),
      .cout  (seg_co[k])
    );
  end

  assign bus.valid_out = vd[SEGS];
  assign bus.sum       = merged[SEGS-1];

`ifdef ADD_NP_OVF_EN
  logic xmsb;
  logic ymsb;

  // Operand sign bits delayed one more stage to line up with the final sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      xmsb <= 1'b0;
      ymsb <= 1'b0;
    end else if (ena) begin
      xmsb <= xd[SEGS-1][WIDTH-1];
      ymsb <= yd[SEGS-1][WIDTH-1];
    end
  end

  assign bus.cout = seg_co[SEGS-1];
  assign bus.ovf  = (xmsb == ymsb) && (merged[SEGS-1][WIDTH-1] != xmsb);
`endif

endmodule
